control_cmd_dispatch: RTL and testbench

Command-stream sequencer that sits between the byte receiver and the framebuffer command handlers (`control_cmd_readpixel` and its siblings). It decodes the opcode byte, forwards each later byte strobe to exactly one selected handler until that handler reports `done`, and owns the single framebuffer write port. It multiplexes the selected handler's address, data and write-enable onto that port and regenerates a glitch-free `ram_access_start` toggle.

---
 rtl/control_cmd_dispatch_if.sv | 54 +++++
 rtl/control_cmd_dispatch.sv | 213 +++++++++++++++++++++
 tb/tb_control_cmd_dispatch.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_cmd_dispatch_if.sv
// control_cmd_dispatch_if
//   Bundles the byte stream, the handler fan-out/fan-in bus, the framebuffer
//   write port and the status/debug outputs of control_cmd_dispatch.
//   master : the dispatcher (drives strobes, write port, status)
//   slave  : the environment (byte receiver + handlers + framebuffer)
//   Handler vectors are flattened; handler i occupies slice i.
interface control_cmd_dispatch_if #(
  parameter int NUM_CMDS = 4,
  parameter int ROW_W    = 8,
  parameter int COL_W    = 9,
  parameter int PW       = 1
);
  // byte stream
  logic [7:0]              data_in;
  logic                    enable;
  // handler bus
  logic [NUM_CMDS-1:0]       sub_enable;
  logic [NUM_CMDS-1:0]       sub_clear;
  logic [NUM_CMDS-1:0]       sub_done;
  logic [NUM_CMDS*ROW_W-1:0] sub_row;
  logic [NUM_CMDS*COL_W-1:0] sub_column;
  logic [NUM_CMDS*PW-1:0]    sub_pixel;
  logic [NUM_CMDS*8-1:0]     sub_data;
  logic [NUM_CMDS-1:0]       sub_we;
  logic [NUM_CMDS-1:0]       sub_as;
  // framebuffer write port
  logic [ROW_W-1:0]        ram_row;
  logic [COL_W-1:0]        ram_column;
  logic [PW-1:0]           ram_pixel;
  logic [7:0]              ram_data;
  logic                    ram_write_enable;
  logic                    ram_access_start;
  // status / debug
  logic                    busy;
  logic [2:0]              sel;
  logic                    bad_opcode;
  logic                    timeout;

  modport master (
    input  data_in, enable,
    input  sub_done, sub_row, sub_column, sub_pixel, sub_data, sub_we, sub_as,
    output sub_enable, sub_clear,
    output ram_row, ram_column, ram_pixel, ram_data, ram_write_enable, ram_access_start,
    output busy, sel, bad_opcode, timeout
  );

  modport slave (
    output data_in, enable,
    output sub_done, sub_row, sub_column, sub_pixel, sub_data, sub_we, sub_as,
    input  sub_enable, sub_clear,
    input  ram_row, ram_column, ram_pixel, ram_data, ram_write_enable, ram_access_start,
    input  busy, sel, bad_opcode, timeout
  );
endinterface

// File: rtl/control_cmd_dispatch.sv
// control_cmd_dispatch
//   Decodes the opcode byte of the command stream, routes every following
//   byte strobe to the selected handler until it reports done (or the
//   watchdog expires), and owns the single framebuffer write port, muxing
//   the selected handler's address/data/we onto registered outputs and
//   regenerating a glitch-free access-start toggle.
// Ports
//   i_clk    : system clock
//   i_reset  : asynchronous active-low reset
//   bus      : control_cmd_dispatch_if.master (stream, handler bus,
//              write port, busy/sel/bad_opcode/timeout)
//
//   state       | meaning
//   ------------+----------------------------------------------------
//   ST_IDLE     | waiting for an opcode strobe; decode data_in
//   ST_DISPATCH | forwarding strobes to handler r_sel until done/timeout
module control_cmd_dispatch #(
  parameter int                    BYTES_PER_PIXEL = 2,
  parameter int                    NUM_CMDS        = 4,
  parameter logic [NUM_CMDS*8-1:0] OPCODE_TABLE    = 32'h5A_46_52_4C,
  parameter int                    TIMEOUT_CYCLES  = 4096,
  parameter int                    ROW_W           = 8,
  parameter int                    COL_W           = 9
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  control_cmd_dispatch_if.master bus
);

  // pixel-select width: one bit minimum even for single-byte pixels
  localparam int PW   = (BYTES_PER_PIXEL < 2) ? 1 : $clog2(BYTES_PER_PIXEL);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  // counter value seen during the TIMEOUT_CYCLES-th silent cycle
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_sel;
  logic [2:0]          w_sel_next;
  logic [WD_W-1:0]     r_wdog;
  logic [NUM_CMDS-1:0] r_prev_as;

  logic [ROW_W-1:0]    r_ram_row;
  logic [COL_W-1:0]    r_ram_column;
  logic [PW-1:0]       r_ram_pixel;
  logic [7:0]          r_ram_data;
  logic                r_ram_we;
  logic                r_ram_as;

  logic                w_match;
  logic [2:0]          w_match_idx;

  logic                w_sel_done;
  logic                w_sel_as;
  logic                w_sel_prev_as;
  logic                w_sel_we;
  logic [ROW_W-1:0]    w_sel_row;
  logic [COL_W-1:0]    w_sel_column;
  logic [PW-1:0]       w_sel_pixel;
  logic [7:0]          w_sel_data;

  logic [NUM_CMDS-1:0] w_sub_enable;
  logic [NUM_CMDS-1:0] w_sub_clear;
  logic                w_bad_opcode;
  logic                w_timeout;
  logic                w_active;

  // Opcode decode: scanning downwards leaves the lowest matching index.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = 3'd0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (bus.data_in == OPCODE_TABLE[i*8 +: 8]) begin
        w_match     = 1'b1;
        w_match_idx = 3'(i);
      end
    end
  end

  // Selected-handler view of the flattened handler bus.
  always_comb begin
    w_sel_done    = 1'b0;
    w_sel_as      = 1'b0;
    w_sel_prev_as = 1'b0;
    w_sel_we      = 1'b0;
    w_sel_row     = '0;
    w_sel_column  = '0;
    w_sel_pixel   = '0;
    w_sel_data    = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (r_sel == 3'(i)) begin
        w_sel_done    = bus.sub_done[i];
        w_sel_as      = bus.sub_as[i];
        w_sel_prev_as = r_prev_as[i];
        w_sel_we      = bus.sub_we[i];
        w_sel_row     = bus.sub_row[i*ROW_W +: ROW_W];
        w_sel_column  = bus.sub_column[i*COL_W +: COL_W];
        w_sel_pixel   = bus.sub_pixel[i*PW +: PW];
        w_sel_data    = bus.sub_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_sub_enable = '0;
    w_sub_clear  = '0;
    w_bad_opcode = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable) begin
          if (w_match) begin
            w_state_next = ST_DISPATCH;
            w_sel_next   = w_match_idx;
          end else begin
            w_bad_opcode = 1'b1;
          end
        end
      end
      ST_DISPATCH: begin
        for (int i = 0; i < NUM_CMDS; i++) begin
          w_sub_enable[i] = bus.enable && (r_sel == 3'(i));
        end
        // done wins over the watchdog; a strobe in the done cycle is still
        // forwarded above and never decoded
        if (w_sel_done) begin
          w_state_next = ST_IDLE;
        end else if (!bus.enable && (r_wdog == WD_LAST)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
          for (int i = 0; i < NUM_CMDS; i++) begin
            w_sub_clear[i] = (r_sel == 3'(i));
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Port ownership only while the handler stays selected: the done/timeout
  // cycle already counts as released, so no write or edge leaks out of it.
  assign w_active = (r_state == ST_DISPATCH) && (w_state_next == ST_DISPATCH);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wdog       <= '0;
      r_prev_as    <= '0;
      r_ram_row    <= '0;
      r_ram_column <= '0;
      r_ram_pixel  <= '0;
      r_ram_data   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_as     <= 1'b0;
    end else begin
      // every handler's toggle is tracked, so a later selection never
      // sees a stale difference and cannot emit a spurious edge
      r_prev_as <= bus.sub_as;

      if (w_active && !bus.enable) begin
        r_wdog <= r_wdog + 1'b1;
      end else begin
        r_wdog <= '0;
      end

      if (w_active) begin
        r_ram_row    <= w_sel_row;
        r_ram_column <= w_sel_column;
        r_ram_pixel  <= w_sel_pixel;
        r_ram_data   <= w_sel_data;
        r_ram_we     <= w_sel_we;
        if (w_sel_as != w_sel_prev_as) begin
          r_ram_as <= ~r_ram_as;
        end
      end else begin
        r_ram_data <= '0;
        r_ram_we   <= 1'b0;
      end
    end
  end

  assign bus.sub_enable       = w_sub_enable;
  assign bus.sub_clear        = w_sub_clear;
  assign bus.bad_opcode       = w_bad_opcode;
  assign bus.timeout          = w_timeout;
  assign bus.busy             = (r_state == ST_DISPATCH);
  assign bus.sel              = r_sel;
  assign bus.ram_row          = r_ram_row;
  assign bus.ram_column       = r_ram_column;
  assign bus.ram_pixel        = r_ram_pixel;
  assign bus.ram_data         = r_ram_data;
  assign bus.ram_write_enable = r_ram_we;
  assign bus.ram_access_start = r_ram_as;

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// tb_control_cmd_dispatch
//   Directed scenarios for the command dispatcher followed by a randomized
//   run checked every cycle against a behavioural model of the dispatcher.
module tb_control_cmd_dispatch;

  localparam int          NC    = 4;
  localparam int          ROW_W = 8;
  localparam int          COL_W = 9;
  localparam int          PW    = 1;
  localparam int          TO    = 16;
  localparam logic [31:0] OPC   = 32'h5A_46_52_4C;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  control_cmd_dispatch_if #(.NUM_CMDS(NC), .ROW_W(ROW_W), .COL_W(COL_W), .PW(PW)) bus ();

  control_cmd_dispatch #(
    .BYTES_PER_PIXEL(2),
    .NUM_CMDS(NC),
    .OPCODE_TABLE(OPC),
    .TIMEOUT_CYCLES(TO),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached before summary");
    $fatal(1, "time limit");
  end

  function automatic int find_op(input logic [7:0] b);
    logic [31:0] tbl;
    tbl = OPC;
    for (int i = 0; i < NC; i++) if (tbl[i*8 +: 8] == b) return i;
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.enable     = 1'b0;
    bus.data_in    = 8'h00;
    bus.sub_done   = '0;
    bus.sub_row    = '0;
    bus.sub_column = '0;
    bus.sub_pixel  = '0;
    bus.sub_data   = '0;
    bus.sub_we     = '0;
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.enable  = 1'b1;
    bus.data_in = b;
  endtask

  task automatic set_sub(input int i, input logic [7:0] row, input logic [8:0] col,
                         input logic pix, input logic [7:0] d, input logic we);
    bus.sub_row[i*ROW_W +: ROW_W]    = row;
    bus.sub_column[i*COL_W +: COL_W] = col;
    bus.sub_pixel[i*PW +: PW]        = pix;
    bus.sub_data[i*8 +: 8]           = d;
    bus.sub_we[i]                    = we;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.sub_as = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.sub_as = '0;
    #3;
    n_checks++;
    if ({bus.busy, bus.sel, bus.ram_row, bus.ram_column, bus.ram_pixel, bus.ram_data,
         bus.ram_write_enable, bus.ram_access_start} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs got busy=%b sel=%0d row=%h col=%h data=%h we=%b as=%b want all 0",
               bus.busy, bus.sel, bus.ram_row, bus.ram_column, bus.ram_data,
               bus.ram_write_enable, bus.ram_access_start);
    end
    n_checks++;
    if ({bus.sub_enable, bus.sub_clear, bus.bad_opcode, bus.timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_pulses got en=%b clr=%b bad=%b to=%b want 0",
               bus.sub_enable, bus.sub_clear, bus.bad_opcode, bus.timeout);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_readpixel();
    int   en0 = 0;
    int   en_other = 0;
    logic as0;
    logic [7:0] payload [4];
    payload = '{8'h03, 8'h05, 8'hAB, 8'hCD};
    as0 = bus.ram_access_start;
    strobe(8'h4C);
    #1;
    en_other += $countones(bus.sub_enable);
    next_cycle();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.sel !== 3'd0) begin
      n_fail++;
      $display("FAIL rp_select got busy=%b sel=%0d want busy=1 sel=0", bus.busy, bus.sel);
    end
    for (int k = 0; k < 4; k++) begin
      strobe(payload[k]);
      if (k == 3) begin
        set_sub(0, 8'h03, 9'h005, 1'b1, 8'hAB, 1'b1);
        bus.sub_as[0] = ~bus.sub_as[0];
      end
      #1;
      en0 += int'(bus.sub_enable[0]);
      en_other += $countones(bus.sub_enable[NC-1:1]);
      next_cycle();
    end
    n_checks++;
    if (bus.ram_data !== 8'hAB || bus.ram_pixel !== 1'b1 || bus.ram_write_enable !== 1'b1 ||
        bus.ram_row !== 8'h03 || bus.ram_column !== 9'h005 || bus.ram_access_start !== ~as0) begin
      n_fail++;
      $display("FAIL rp_write1 got data=%h pix=%b we=%b row=%h col=%h as=%b want AB 1 1 03 005 %b",
               bus.ram_data, bus.ram_pixel, bus.ram_write_enable, bus.ram_row,
               bus.ram_column, bus.ram_access_start, ~as0);
    end
    bus.enable = 1'b0;
    set_sub(0, 8'h03, 9'h005, 1'b0, 8'hCD, 1'b1);
    bus.sub_as[0] = ~bus.sub_as[0];
    next_cycle();
    n_checks++;
    if (bus.ram_data !== 8'hCD || bus.ram_pixel !== 1'b0 || bus.ram_write_enable !== 1'b1 ||
        bus.ram_access_start !== as0) begin
      n_fail++;
      $display("FAIL rp_write2 got data=%h pix=%b we=%b as=%b want CD 0 1 %b",
               bus.ram_data, bus.ram_pixel, bus.ram_write_enable, bus.ram_access_start, as0);
    end
    set_sub(0, 8'h03, 9'h005, 1'b0, 8'h00, 1'b0);
    bus.sub_done[0] = 1'b1;
    next_cycle();
    bus.sub_done = '0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ram_write_enable !== 1'b0 || bus.ram_data !== 8'h00 ||
        bus.ram_row !== 8'h03) begin
      n_fail++;
      $display("FAIL rp_after_done got busy=%b we=%b data=%h row=%h want 0 0 00 03",
               bus.busy, bus.ram_write_enable, bus.ram_data, bus.ram_row);
    end
    n_checks++;
    if (en0 != 4 || en_other != 0) begin
      n_fail++;
      $display("FAIL rp_strobe_count got sel0=%0d other=%0d want 4 0", en0, en_other);
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) b = 8'h00;
      else begin
        b = 8'($urandom);
        while (find_op(b) >= 0) b = 8'($urandom);
      end
      strobe(b);
      #1;
      n_checks++;
      if (bus.bad_opcode !== 1'b1 || bus.sub_enable !== '0) begin
        n_fail++;
        $display("FAIL bad_pulse op=%h got bad=%b en=%b want 1 0", b, bus.bad_opcode, bus.sub_enable);
      end
      next_cycle();
      bus.enable = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.bad_opcode !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_after op=%h got busy=%b bad=%b want 0 0", b, bus.busy, bus.bad_opcode);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic a;
    strobe(8'h4C);
    next_cycle();
    a = bus.ram_access_start;
    strobe(8'h11);
    set_sub(0, 8'h10, 9'h020, 1'b1, 8'h66, 1'b1);
    bus.sub_as[0] = ~bus.sub_as[0];
    bus.sub_as[1] = ~bus.sub_as[1];
    next_cycle();
    n_checks++;
    if (bus.ram_access_start !== ~a || bus.ram_data !== 8'h66 || bus.sel !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_h0_write got as=%b data=%h sel=%0d want %b 66 0",
               bus.ram_access_start, bus.ram_data, bus.sel, ~a);
    end
    a = bus.ram_access_start;
    strobe(8'h22);
    set_sub(0, 8'h10, 9'h020, 1'b0, 8'h00, 1'b0);
    bus.sub_done[0] = 1'b1;
    #1;
    n_checks++;
    if (bus.sub_enable !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_done_fwd got en=%b want 0001", bus.sub_enable);
    end
    next_cycle();
    bus.sub_done = '0;
    strobe(8'h52);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.sub_enable !== '0 || bus.bad_opcode !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_decode got busy=%b en=%b bad=%b want 0 0 0",
               bus.busy, bus.sub_enable, bus.bad_opcode);
    end
    next_cycle();
    bus.enable = 1'b0;
    n_checks++;
    if (bus.sel !== 3'd1 || bus.busy !== 1'b1 || bus.ram_access_start !== a) begin
      n_fail++;
      $display("FAIL b2b_switch got sel=%0d busy=%b as=%b want 1 1 %b",
               bus.sel, bus.busy, bus.ram_access_start, a);
    end
    set_sub(1, 8'h07, 9'h109, 1'b0, 8'h5E, 1'b1);
    bus.sub_as[1] = ~bus.sub_as[1];
    next_cycle();
    n_checks++;
    if (bus.ram_access_start !== ~a || bus.ram_data !== 8'h5E || bus.ram_row !== 8'h07 ||
        bus.ram_column !== 9'h109) begin
      n_fail++;
      $display("FAIL b2b_h1_write got as=%b data=%h row=%h col=%h want %b 5E 07 109",
               bus.ram_access_start, bus.ram_data, bus.ram_row, bus.ram_column, ~a);
    end
    set_sub(1, 8'h07, 9'h109, 1'b0, 8'h00, 1'b0);
    next_cycle();
    n_checks++;
    if (bus.ram_access_start !== ~a || bus.ram_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_single_edge got as=%b we=%b want %b 0",
               bus.ram_access_start, bus.ram_write_enable, ~a);
    end
    bus.sub_done[1] = 1'b1;
    next_cycle();
    bus.sub_done = '0;
    clear_inputs();
  endtask

  task automatic test_nonselected();
    logic a;
    strobe(8'h4C);
    next_cycle();
    bus.enable = 1'b0;
    a = bus.ram_access_start;
    for (int k = 0; k < 3; k++) begin
      bus.sub_as[2]   = ~bus.sub_as[2];
      bus.sub_done[2] = (k != 1);
      next_cycle();
      n_checks++;
      if (bus.ram_access_start !== a || bus.busy !== 1'b1 || bus.sel !== 3'd0) begin
        n_fail++;
        $display("FAIL ns_ignored k=%0d got as=%b busy=%b sel=%0d want %b 1 0",
                 k, bus.ram_access_start, bus.busy, bus.sel, a);
      end
    end
    bus.sub_done = 4'b0001;
    next_cycle();
    bus.sub_done = '0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ns_done got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_timeout();
    logic exp;
    strobe(8'h4C);
    next_cycle();
    strobe(8'h77);
    next_cycle();
    bus.enable = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      #1;
      exp = (k == TO);
      n_checks++;
      if (bus.timeout !== exp || bus.sub_clear !== {3'b000, exp}) begin
        n_fail++;
        $display("FAIL to_cycle k=%0d got to=%b clr=%b want %b %b",
                 k, bus.timeout, bus.sub_clear, exp, {3'b000, exp});
      end
      next_cycle();
    end
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.timeout !== 1'b0 || bus.sub_clear !== '0) begin
      n_fail++;
      $display("FAIL to_after got busy=%b to=%b clr=%b want 0 0 0",
               bus.busy, bus.timeout, bus.sub_clear);
    end
    next_cycle();
    strobe(8'h4C);
    next_cycle();
    bus.enable = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.sel !== 3'd0) begin
      n_fail++;
      $display("FAIL to_reaccept got busy=%b sel=%0d want 1 0", bus.busy, bus.sel);
    end
    bus.sub_done[0] = 1'b1;
    next_cycle();
    bus.sub_done = '0;
  endtask

  task automatic test_reset_midcmd();
    strobe(8'h4C);
    next_cycle();
    strobe(8'h01);
    set_sub(0, 8'h44, 9'h100, 1'b1, 8'h99, 1'b1);
    bus.sub_as[0] = ~bus.sub_as[0];
    next_cycle();
    bus.enable = 1'b0;
    n_checks++;
    if (bus.ram_write_enable !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstm_pre got we=%b busy=%b want 1 1", bus.ram_write_enable, bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.sel, bus.ram_row, bus.ram_column, bus.ram_pixel, bus.ram_data,
         bus.ram_write_enable, bus.ram_access_start, bus.sub_clear, bus.timeout} !== '0) begin
      n_fail++;
      $display("FAIL rstm_async got busy=%b row=%h data=%h we=%b as=%b clr=%b want all 0",
               bus.busy, bus.ram_row, bus.ram_data, bus.ram_write_enable,
               bus.ram_access_start, bus.sub_clear);
    end
    clear_inputs();
    bus.sub_as = '0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    strobe(8'h4C);
    next_cycle();
    strobe(8'h02);
    set_sub(0, 8'h12, 9'h034, 1'b0, 8'h56, 1'b1);
    bus.sub_as[0] = 1'b1;
    next_cycle();
    bus.enable = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.ram_data !== 8'h56 || bus.ram_access_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rstm_fresh got busy=%b data=%h as=%b want 1 56 1",
               bus.busy, bus.ram_data, bus.ram_access_start);
    end
    set_sub(0, 8'h12, 9'h034, 1'b0, 8'h00, 1'b0);
    bus.sub_done[0] = 1'b1;
    next_cycle();
    bus.sub_done = '0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ram_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL rstm_done got busy=%b we=%b want 0 0", bus.busy, bus.ram_write_enable);
    end
  endtask

  task automatic test_random();
    // model of the dispatcher's observable behaviour
    bit          m_busy = 1'b0;
    int          m_sel = 0;
    int          m_quiet = 0;
    logic [7:0]  m_row = '0;
    logic [8:0]  m_col = '0;
    logic        m_pix = 1'b0;
    logic [7:0]  m_data = '0;
    logic        m_we = 1'b0;
    logic        m_as = 1'b0;
    logic [3:0]  m_last_as = '0;
    // stimulus for this cycle
    logic        en;
    logic [7:0]  d;
    logic [31:0] v_row, v_data;
    logic [35:0] v_col;
    logic [3:0]  v_pix, v_we, v_as, v_done;
    // expectations
    logic [3:0]  e_en, e_clr;
    logic        e_bad, e_to, leaving, quiet_mode;
    bit          nb;
    int          ns, op;
    logic [31:0] tbl;
    tbl = OPC;
    v_as = '0;
    quiet_mode = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) quiet_mode = ~quiet_mode;
      en = quiet_mode ? ($urandom_range(19) == 0) : ($urandom_range(2) == 0);
      d  = ($urandom_range(1) == 1) ? tbl[$urandom_range(NC-1)*8 +: 8] : 8'($urandom);
      v_row  = $urandom;
      v_col  = 36'({$urandom, $urandom});
      v_pix  = 4'($urandom);
      v_data = $urandom;
      v_we   = 4'($urandom);
      v_done = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
      if (m_busy) v_done[m_sel] = ($urandom_range(9) == 0);
      leaving = m_busy && (v_done[m_sel] || (!en && m_quiet == TO - 1));
      begin
        logic [3:0] nxt;
        nxt = v_as ^ (4'($urandom) & 4'($urandom));
        if (leaving) nxt[m_sel] = v_as[m_sel];
        v_as = nxt;
      end
      bus.enable = en;     bus.data_in = d;
      bus.sub_row = v_row; bus.sub_column = v_col; bus.sub_pixel = v_pix;
      bus.sub_data = v_data; bus.sub_we = v_we; bus.sub_as = v_as; bus.sub_done = v_done;
      #1;
      e_en = '0; e_clr = '0; e_bad = 1'b0; e_to = 1'b0;
      nb = m_busy; ns = m_sel;
      if (!m_busy) begin
        if (en) begin
          op = find_op(d);
          if (op >= 0) begin nb = 1'b1; ns = op; m_quiet = 0; end
          else e_bad = 1'b1;
        end
      end else begin
        if (en) e_en[m_sel] = 1'b1;
        if (v_done[m_sel]) nb = 1'b0;
        else if (!en && m_quiet == TO - 1) begin
          e_to = 1'b1; e_clr[m_sel] = 1'b1; nb = 1'b0;
        end else if (en) m_quiet = 0;
        else m_quiet++;
      end
      if (m_busy && !leaving) begin
        m_row  = v_row[m_sel*8 +: 8];
        m_col  = v_col[m_sel*9 +: 9];
        m_pix  = v_pix[m_sel];
        m_data = v_data[m_sel*8 +: 8];
        m_we   = v_we[m_sel];
        if (v_as[m_sel] != m_last_as[m_sel]) m_as = ~m_as;
      end else begin
        m_we = 1'b0; m_data = '0;
      end
      m_last_as = v_as;
      m_busy = nb;
      m_sel  = ns;
      n_checks++;
      if ({bus.sub_enable, bus.sub_clear, bus.bad_opcode, bus.timeout} !== {e_en, e_clr, e_bad, e_to}) begin
        n_fail++;
        $display("FAIL rnd_pulses c=%0d got en=%b clr=%b bad=%b to=%b want en=%b clr=%b bad=%b to=%b",
                 c, bus.sub_enable, bus.sub_clear, bus.bad_opcode, bus.timeout, e_en, e_clr, e_bad, e_to);
      end
      next_cycle();
      n_checks++;
      if ({bus.busy, bus.sel, bus.ram_row, bus.ram_column, bus.ram_pixel, bus.ram_data,
           bus.ram_write_enable, bus.ram_access_start} !==
          {m_busy, 3'(m_sel), m_row, m_col, m_pix, m_data, m_we, m_as}) begin
        n_fail++;
        $display("FAIL rnd_port c=%0d got busy=%b sel=%0d row=%h col=%h pix=%b data=%h we=%b as=%b want %b %0d %h %h %b %h %b %b",
                 c, bus.busy, bus.sel, bus.ram_row, bus.ram_column, bus.ram_pixel, bus.ram_data,
                 bus.ram_write_enable, bus.ram_access_start,
                 m_busy, m_sel, m_row, m_col, m_pix, m_data, m_we, m_as);
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    bus.sub_as = '0;
    test_reset();
    test_readpixel();
    test_bad_opcode();
    test_back_to_back();
    test_nonselected();
    test_timeout();
    test_reset_midcmd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
